// File: rtl/lp_fltr_pkg.sv
// Shared constants and sample/accumulator types for the low-pass filter chain.
// Used by lp_fltr, lp_decim and the neighbouring stages.
package lp_fltr_pkg;

   localparam int DW_DEFAULT         = 8;
   localparam int LOG2_N_DEFAULT     = 2;
   localparam int FIFO_DEPTH_DEFAULT = 4;

   typedef logic [DW_DEFAULT-1:0]                sample_t;
   typedef logic [DW_DEFAULT+LOG2_N_DEFAULT-1:0] acc_t;

   // Pointer width for a power-of-two buffer, never below one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/lp_decim_fifo.sv
// Synchronous output FIFO for lp_decim. The head entry is held in a register so
// rdata_o stays stable while not popped and keeps the last popped value when empty.
module lp_decim_fifo
   import lp_fltr_pkg::*;
#(
   parameter int DW         = DW_DEFAULT,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          empty_o,
   output logic          full_o
);

   localparam int AW = ptr_w(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      // A full FIFO still takes a push when the head leaves in the same cycle.
      do_push  = push_i && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rdata_d  = rdata_q;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // New head comes from the write port when the slot is being filled right now.
      if (count_d != '0) begin
         if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            rdata_d = wdata_i;
         end else begin
            rdata_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
      end
   end

   assign rdata_o = rdata_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(FIFO_DEPTH));

endmodule

// File: rtl/lp_decim.sv
// Box-car average and decimate-by-2^LOG2_N of ce-qualified samples, buffered in a FIFO
// behind a valid/ready output. Define LP_DECIM_ROUND_EN for round-half-up results.
module lp_decim
   import lp_fltr_pkg::*;
#(
   parameter int DW         = DW_DEFAULT,
   parameter int LOG2_N     = LOG2_N_DEFAULT,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ce,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   input  logic          dout_rdy,
   output logic          ovf
);

   localparam int AW = DW + LOG2_N;

   logic [AW-1:0]     acc_q, acc_d;
   logic [LOG2_N-1:0] phase_q, phase_d;
   logic [DW-1:0]     res_q, res_d;
   logic              push_q, push_d;
   logic              ovf_q, ovf_d;
   logic [AW-1:0]     sum;
   logic [AW-1:0]     biased;
   logic [DW-1:0]     result;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;

   always_comb begin
      sum = acc_q + AW'(din);
`ifdef LP_DECIM_ROUND_EN
      biased = sum + AW'(2 ** (LOG2_N - 1));
`else
      biased = sum;
`endif
      result = DW'(biased >> LOG2_N);
   end

   // Block completes on the N-th strobe; the result is staged one cycle before the FIFO.
   always_comb begin
      acc_d   = acc_q;
      phase_d = phase_q;
      res_d   = res_q;
      push_d  = 1'b0;
      if (ce) begin
         if (phase_q == '1) begin
            res_d   = result;
            push_d  = 1'b1;
            acc_d   = '0;
            phase_d = '0;
         end else begin
            acc_d   = sum;
            phase_d = phase_q + LOG2_N'(1);
         end
      end
   end

   assign pop   = dout_vld && dout_rdy;
   assign ovf_d = ovf_q || (push_q && fifo_full && !pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         phase_q <= '0;
         res_q   <= '0;
         push_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         phase_q <= phase_d;
         res_q   <= res_d;
         push_q  <= push_d;
         ovf_q   <= ovf_d;
      end
   end

   lp_decim_fifo #(
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_q),
      .wdata_i (res_q),
      .pop_i   (pop),
      .rdata_o (dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign dout_vld = !fifo_empty;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_lp_decim.sv
// Bench for lp_decim: average-of-N reference model feeding an expected queue,
// checked at the output handshake plus scenario-specific timing and flag checks.
module tb_lp_decim;

   localparam int DW         = 8;
   localparam int LOG2_N     = 2;
   localparam int N          = 1 << LOG2_N;
   localparam int FIFO_DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          dout_rdy = 1'b1;
   logic          ovf;

   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;
   bit drop_next = 1'b0;
   int blk_q[$];
   logic [DW-1:0] exp_q[$];

   lp_decim #(
      .DW         (DW),
      .LOG2_N     (LOG2_N),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .din      (din),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .ovf      (ovf)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [DW-1:0] model_avg(input int s[$]);
      int total = 0;
      foreach (s[i]) total += s[i];
`ifdef LP_DECIM_ROUND_EN
      total += N / 2;
`endif
      return DW'(total / N);
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && dout_vld) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_valid: dout=%0d with nothing expected", dout);
         end else begin
            if (dout !== exp_q[0]) begin
               errors++;
               $display("FAIL sb_dout: got %0d expected %0d", dout, exp_q[0]);
            end
            if (dout_rdy) begin
               void'(exp_q.pop_front());
               pop_cnt++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      blk_q.push_back(int'(d));
      if (blk_q.size() == N) begin
         if (!drop_next) exp_q.push_back(model_avg(blk_q));
         drop_next = 1'b0;
         blk_q.delete();
      end
      ce  = 1'b1;
      din = d;
      tick();
      ce  = 1'b0;
      din = DW'($urandom);
   endtask

   task automatic send_block(input logic [DW-1:0] v);
      for (int i = 0; i < N; i++) send(v);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int cyc = 0;
      while ((exp_q.size() != 0 || dout_vld) && cyc < budget) begin
         tick();
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0 || dout_vld) begin
         errors++;
         $display("FAIL %s_drain: %0d results still pending, dout_vld=%0b after %0d cycles",
                  name, exp_q.size(), dout_vld, budget);
      end
   endtask

   task automatic apply_reset();
      #3 rst_n = 1'b0;
      exp_q.delete();
      blk_q.delete();
      drop_next = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      ce = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", dout_vld); end
      checks++;
      if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
      apply_reset();
   endtask

   task automatic test_basic();
      int vld_cycles = 0;
      dout_rdy = 1'b1;
      send(8'd10); send(8'd20); send(8'd30); send(8'd40);
      checks++;
      if (dout_vld !== 1'b0) begin errors++; $display("FAIL basic_early: dout_vld=%0b expected 0 right after 4th sample", dout_vld); end
      tick();
      checks++;
      if (dout_vld !== 1'b1 || dout !== 8'd25) begin
         errors++;
         $display("FAIL basic_latency: vld=%0b dout=%0d expected vld=1 dout=25", dout_vld, dout);
      end
      for (int i = 0; i < 4; i++) begin
         if (dout_vld) vld_cycles++;
         tick();
      end
      checks++;
      if (vld_cycles != 1) begin errors++; $display("FAIL basic_one_cycle: valid for %0d cycles expected 1", vld_cycles); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b expected 0", ovf); end
   endtask

   task automatic test_gapped();
      int p0 = pop_cnt;
      logic [DW-1:0] s[4] = '{8'd10, 8'd20, 8'd30, 8'd40};
      dout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(s[i]);
         repeat ($urandom_range(1, 4)) tick();
      end
      wait_drain("gapped", 20);
      checks++;
      if (pop_cnt - p0 != 1) begin errors++; $display("FAIL gapped_count: %0d results expected 1", pop_cnt - p0); end
   endtask

   task automatic test_rounding();
      logic [DW-1:0] want;
`ifdef LP_DECIM_ROUND_EN
      want = 8'd2;
`else
      want = 8'd1;
`endif
      dout_rdy = 1'b1;
      send(8'd1); send(8'd1); send(8'd2); send(8'd2);
      tick();
      checks++;
      if (dout_vld !== 1'b1 || dout !== want) begin
         errors++;
         $display("FAIL round_small: vld=%0b dout=%0d expected %0d", dout_vld, dout, want);
      end
      send_block(8'd255);
      tick();
      checks++;
      if (dout_vld !== 1'b1 || dout !== 8'd255) begin
         errors++;
         $display("FAIL round_max: vld=%0b dout=%0d expected 255", dout_vld, dout);
      end
      wait_drain("round", 20);
   endtask

   task automatic test_random();
      dout_rdy = 1'b1;
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < N; i++) begin
            dout_rdy = ($urandom_range(0, 3) != 0);
            send(DW'($urandom));
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      dout_rdy = 1'b1;
      wait_drain("random", 40);
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL random_ovf: got %0b expected 0", ovf); end
   endtask

   task automatic test_full_pop();
      int p0 = pop_cnt;
      dout_rdy = 1'b0;
      for (int b = 1; b <= 4; b++) send_block(DW'(b));
      for (int i = 0; i < N - 1; i++) send(8'd5);
      send(8'd5);
      dout_rdy = 1'b1;
      tick();
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %0b expected 0", ovf); end
      wait_drain("fullpop", 20);
      checks++;
      if (pop_cnt - p0 != 5) begin errors++; $display("FAIL fullpop_count: %0d results expected 5", pop_cnt - p0); end
   endtask

   task automatic test_overflow();
      int p0 = pop_cnt;
      dout_rdy = 1'b0;
      for (int b = 1; b <= 4; b++) send_block(DW'(b));
      tick();
      checks++;
      if (ovf !== 1'b0 || dout_vld !== 1'b1 || dout !== 8'd1) begin
         errors++;
         $display("FAIL ovf_full: ovf=%0b vld=%0b dout=%0d expected 0 1 1", ovf, dout_vld, dout);
      end
      drop_next = 1'b1;
      for (int i = 0; i < N - 1; i++) send(8'd5);
      drop_next = 1'b1;
      send(8'd5);
      repeat (2) tick();
      checks++;
      if (ovf !== 1'b1 || dout !== 8'd1) begin
         errors++;
         $display("FAIL ovf_set: ovf=%0b dout=%0d expected ovf=1 dout=1", ovf, dout);
      end
      dout_rdy = 1'b1;
      wait_drain("ovf", 20);
      checks++;
      if (pop_cnt - p0 != 4) begin errors++; $display("FAIL ovf_count: %0d results expected 4", pop_cnt - p0); end
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", ovf); end
   endtask

   task automatic test_reset_mid();
      dout_rdy = 1'b0;
      send_block(8'd7);
      send(8'd100); send(8'd100);
      #3 rst_n = 1'b0;
      exp_q.delete();
      blk_q.delete();
      #1;
      checks++;
      if (dout_vld !== 1'b0 || ovf !== 1'b0 || dout !== '0) begin
         errors++;
         $display("FAIL midrst_async: vld=%0b ovf=%0b dout=%0d expected 0 0 0", dout_vld, ovf, dout);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      dout_rdy = 1'b1;
      send(8'd4); send(8'd8); send(8'd12); send(8'd16);
      tick();
      checks++;
      if (dout_vld !== 1'b1 || dout !== 8'd10) begin
         errors++;
         $display("FAIL midrst_result: vld=%0b dout=%0d expected 10", dout_vld, dout);
      end
      wait_drain("midrst", 20);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_rounding();
      test_random();
      test_full_pop();
      test_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
